// File: rtl/stage_bus_controller_if.sv
// Stage-counter / memory-bus signal bundle for stage_bus_controller.
// master = the controller; slave = the stage counter, datapath and bus side.
interface stage_bus_controller_if;
  logic [2:0] stage_in;
  logic       mem_op;
  logic       mem_we;
  logic       bus_ack;
  logic       stage_hold;
  logic [7:0] stage_en;
  logic       bus_req;
  logic       bus_we;
  logic       bus_is_fetch;
  logic       bus_error;

  modport master (
    input  stage_in, mem_op, mem_we, bus_ack,
    output stage_hold, stage_en, bus_req, bus_we, bus_is_fetch, bus_error
  );

  modport slave (
    output stage_in, mem_op, mem_we, bus_ack,
    input  stage_hold, stage_en, bus_req, bus_we, bus_is_fetch, bus_error
  );
endinterface

// File: rtl/stage_bus_controller.sv
// Starts a req/ack bus access when the fetch stage or a load/store memory stage is entered; bus_req follows one cycle later.
// The counter is held (stage_hold) from the entry cycle until ack or timeout; stage_en is gated by that hold.
module stage_bus_controller #(
  parameter int NUM_STAGES  = 5,
  parameter int FETCH_STAGE = 0,
  parameter int MEM_STAGE   = 3,
  parameter int TIMEOUT     = 15
) (
  input logic                    clk,
  input logic                    rst,
  stage_bus_controller_if.master sb
);

  localparam logic [2:0] FETCH_S  = 3'(FETCH_STAGE);
  localparam logic [2:0] MEM_S    = 3'(MEM_STAGE);
  localparam logic [3:0] NUM_S    = 4'(NUM_STAGES);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] prev_stage;
  logic       prev_valid;
  logic [7:0] tmo_cnt;
  logic       entry;
  logic       in_range;
  logic       bus_entry;
  logic       timeout_hit;
  logic       hold;
  logic [7:0] en;
  logic       req_q;
  logic       we_q;
  logic       fetch_q;
  logic       err_q;

  assign in_range    = ({1'b0, sb.stage_in} < NUM_S);
  assign entry       = !prev_valid || (sb.stage_in != prev_stage);
  assign bus_entry   = entry && in_range &&
                       ((sb.stage_in == FETCH_S) || ((sb.stage_in == MEM_S) && sb.mem_op));
  assign timeout_hit = (state == REQ) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus_entry) state_nxt = REQ;
      REQ:     if (sb.bus_ack || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hold = 1'b0;
    en   = 8'h00;
    case (state)
      IDLE:    hold = bus_entry;
      REQ:     hold = !sb.bus_ack && !timeout_hit;
      default: hold = 1'b0;
    endcase
    for (int i = 0; i < 8; i++) begin
      en[i] = (sb.stage_in == 3'(i)) && (i < NUM_STAGES) && !hold;
    end
  end

  // Access attributes are captured on the entry cycle so later mem_op/mem_we changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_stage <= 3'd0;
      prev_valid <= 1'b0;
      tmo_cnt    <= 8'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      fetch_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      prev_stage <= sb.stage_in;
      prev_valid <= 1'b1;
      req_q      <= (state_nxt == REQ);
      if (state == IDLE) begin
        tmo_cnt <= 8'd0;
        if (bus_entry) begin
          fetch_q <= (sb.stage_in == FETCH_S);
          we_q    <= sb.mem_we && (sb.stage_in != FETCH_S);
        end
      end else if (!sb.bus_ack) begin
        if (tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 8'd1;
        if (timeout_hit) err_q <= 1'b1;
      end
    end
  end

  assign sb.stage_hold   = hold;
  assign sb.stage_en     = en;
  assign sb.bus_req      = req_q;
  assign sb.bus_we       = we_q;
  assign sb.bus_is_fetch = fetch_q;
  assign sb.bus_error    = err_q;

endmodule

// File: tb/tb_stage_bus_controller.sv
// Directed bench for stage_bus_controller with TIMEOUT=4: fetch, load/store, sweeps, timeout, reset-in-REQ.
module tb_stage_bus_controller;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  stage_bus_controller_if sb ();

  stage_bus_controller #(
    .NUM_STAGES (5),
    .FETCH_STAGE(0),
    .MEM_STAGE  (3),
    .TIMEOUT    (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sb (sb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then settle before checks.
  task automatic cyc(input logic r, input logic [2:0] stg, input logic mop,
                     input logic mwe, input logic ack);
    @(negedge clk);
    rst         = r;
    sb.stage_in = stg;
    sb.mem_op   = mop;
    sb.mem_we   = mwe;
    sb.bus_ack  = ack;
    #1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    sb.stage_in = 3'd0;
    sb.mem_op   = 1'b0;
    sb.mem_we   = 1'b0;
    sb.bus_ack  = 1'b0;

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);

    // First post-reset cycle: fetch entry
    cyc(0, 0, 0, 0, 0);
    chk("rst_req",   sb.bus_req, 0);
    chk("rst_we",    sb.bus_we, 0);
    chk("rst_fetch", sb.bus_is_fetch, 0);
    chk("rst_err",   sb.bus_error, 0);
    chk("c1_hold",   sb.stage_hold, 1);
    chk("c1_en",     sb.stage_en, 8'h00);
    cyc(0, 0, 0, 0, 0);
    chk("c2_req",    sb.bus_req, 1);
    chk("c2_fetch",  sb.bus_is_fetch, 1);
    chk("c2_we",     sb.bus_we, 0);
    chk("c2_hold",   sb.stage_hold, 1);
    cyc(0, 0, 0, 0, 0);
    chk("c3_hold",   sb.stage_hold, 1);
    cyc(0, 0, 0, 0, 1);
    chk("fack_hold", sb.stage_hold, 0);
    chk("fack_en",   sb.stage_en, 8'h01);

    // Non-bus stages
    cyc(0, 1, 0, 0, 0);
    chk("s1_req",    sb.bus_req, 0);
    chk("s1_hold",   sb.stage_hold, 0);
    chk("s1_en",     sb.stage_en, 8'h02);
    cyc(0, 2, 0, 0, 0);
    chk("s2_en",     sb.stage_en, 8'h04);

    // Store in stage 3, ack after one cycle
    cyc(0, 3, 1, 1, 0);
    chk("st_hold",   sb.stage_hold, 1);
    chk("st_en0",    sb.stage_en, 8'h00);
    cyc(0, 3, 1, 1, 1);
    chk("st_req",    sb.bus_req, 1);
    chk("st_we",     sb.bus_we, 1);
    chk("st_fetch",  sb.bus_is_fetch, 0);
    chk("st_en",     sb.stage_en, 8'h08);
    cyc(0, 4, 0, 0, 0);
    chk("s4_req",    sb.bus_req, 0);
    chk("s4_hold",   sb.stage_hold, 0);
    chk("s4_en",     sb.stage_en, 8'h10);

    // Fetch with immediate ack, then stage 3 without mem_op
    cyc(0, 0, 0, 0, 0);
    chk("f2_hold",   sb.stage_hold, 1);
    cyc(0, 0, 0, 0, 1);
    chk("f2_req",    sb.bus_req, 1);
    chk("f2_en",     sb.stage_en, 8'h01);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 2, 0, 0, 0);
    cyc(0, 3, 0, 1, 0);
    chk("nm_hold",   sb.stage_hold, 0);
    chk("nm_en",     sb.stage_en, 8'h08);
    cyc(0, 4, 0, 0, 0);
    chk("nm_req",    sb.bus_req, 0);

    // Fetch that times out after 4 REQ cycles
    cyc(0, 0, 0, 0, 0);
    chk("to_hold0",  sb.stage_hold, 1);
    for (int k = 1; k <= 3; k++) begin
      cyc(0, 0, 0, 0, 0);
      chk("to_holdk", sb.stage_hold, 1);
    end
    cyc(0, 0, 0, 0, 0);
    chk("to_rel",    sb.stage_hold, 0);
    chk("to_en",     sb.stage_en, 8'h01);
    chk("to_err0",   sb.bus_error, 0);
    cyc(0, 1, 0, 0, 0);
    chk("to_err1",   sb.bus_error, 1);
    chk("to_req",    sb.bus_req, 0);
    chk("to_en1",    sb.stage_en, 8'h02);

    // Load after the timeout: error stays sticky
    cyc(0, 2, 0, 0, 0);
    cyc(0, 3, 1, 0, 0);
    chk("ld_hold",   sb.stage_hold, 1);
    cyc(0, 3, 0, 1, 1);
    chk("ld_req",    sb.bus_req, 1);
    chk("ld_we",     sb.bus_we, 0);
    chk("ld_err",    sb.bus_error, 1);
    chk("ld_en",     sb.stage_en, 8'h08);

    // Spurious ack in IDLE
    cyc(0, 4, 0, 0, 1);
    chk("sp_hold",   sb.stage_hold, 0);
    chk("sp_en",     sb.stage_en, 8'h10);
    cyc(0, 0, 0, 0, 0);
    chk("sp_req",    sb.bus_req, 0);
    chk("sp_hold2",  sb.stage_hold, 1);

    // Reset while in REQ
    cyc(0, 0, 0, 0, 0);
    chk("rq_req",    sb.bus_req, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rr_req",    sb.bus_req, 0);
    chk("rr_err",    sb.bus_error, 0);
    chk("rr_hold",   sb.stage_hold, 1);

    // Ack coinciding with the timeout cycle is a normal completion
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("ta_hold",   sb.stage_hold, 0);
    cyc(0, 1, 0, 0, 0);
    chk("ta_err",    sb.bus_error, 0);
    chk("ta_req",    sb.bus_req, 0);

    // Out-of-range stages
    cyc(0, 5, 1, 0, 0);
    chk("or5_en",    sb.stage_en, 8'h00);
    chk("or5_hold",  sb.stage_hold, 0);
    cyc(0, 7, 1, 0, 0);
    chk("or7_en",    sb.stage_en, 8'h00);
    chk("or_req",    sb.bus_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=%0d exp=%0d", 1, 0);
    $fatal(1, "watchdog");
  end
endmodule
